// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
//   rx_state_e  : receiver FSM states
//   rx_entry_t  : FIFO entry {ferr, perr, data}, data sized for the widest frame
//   MIN_BITS    : smallest supported data width per frame
//   parity_of() : XOR reduction of the received data bits
//   maj3()      : 2-of-3 vote used by the oversampling front end
package uart_rx_pkg;

  localparam int MAX_DATA_W = 15;
  localparam int MIN_BITS   = 5;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic STOP_ONE  = 1'b0;
  localparam logic STOP_TWO  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_WAIT_IDLE
  } rx_state_e;

  typedef struct packed {
    logic                  ferr;
    logic                  perr;
    logic [MAX_DATA_W-1:0] data;
  } rx_entry_t;

  function automatic logic parity_of(input logic [MAX_DATA_W-1:0] d);
    return ^d;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// First-word fall-through synchronous FIFO.
//   push_i/wdata_i : write side; a push while full is accepted only with a same-cycle pop
//   pop_i          : advances the head; ignored while empty
//   clr_i          : flush, overrides push and pop
//   rdata_o        : head entry (valid while !empty_o)
//   full_o/empty_o/level_o : occupancy status
module uart_rx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  input  logic                         clr_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == LVL_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop_i & ~empty_o & ~clr_i;
    push_ok  = push_i & ~clr_i & (~full_o | pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_fifo_gen.sv
// Parametrised UART receiver with an error-tagged receive FIFO.
//   rx_i                : pad-side serial input (idle high), 2-FF synchronised
//   cfg_*               : enable, baud divider, data bits, parity, stop bits
//   rx_data_o/perr/ferr : FIFO head, zero while rx_valid_o is low
//   rx_valid_o/rx_ready_i : pop handshake; fifo_clr_i flushes
//   fifo_level_o, busy_o, break_o (pulse), err_ovr_o (sticky, err_clr_i clears)
// Build option: define UART_RX_MAJORITY_EN to take every bit sample as a
// 2-of-3 vote over the sample cycle and the two before it (cfg_div_i >= 4).
module uart_rx_fifo_gen #(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              rx_i,
  input  logic                              cfg_en_i,
  input  logic [DIV_W-1:0]                  cfg_div_i,
  input  logic [3:0]                        cfg_bits_i,
  input  logic                              cfg_parity_en_i,
  input  logic                              cfg_parity_odd_i,
  input  logic                              cfg_stop2_i,
  input  logic                              fifo_clr_i,
  output logic [DATA_W-1:0]                 rx_data_o,
  output logic                              rx_perr_o,
  output logic                              rx_ferr_o,
  output logic                              rx_valid_o,
  input  logic                              rx_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_o,
  output logic                              busy_o,
  output logic                              break_o,
  output logic                              err_ovr_o,
  input  logic                              err_clr_i
);
  import uart_rx_pkg::*;

  localparam int ENTRY_W = $bits(rx_entry_t);
`ifdef UART_RX_MAJORITY_EN
  localparam int HIST_W = 2;
`else
  localparam int HIST_W = 1;
`endif

  function automatic logic [3:0] clamp_bits(input logic [3:0] b);
    if (b < 4'(MIN_BITS)) return 4'(MIN_BITS);
    if (b > 4'(DATA_W))   return 4'(DATA_W);
    return b;
  endfunction

  logic [1:0]        sync_q, sync_d;
  logic [HIST_W-1:0] hist_q, hist_d;
  logic              rxs, bit_s, sample;
  rx_state_e         state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        bitc_q, bitc_d, nbits;
  logic              push_q, push_d, ovr_q, ovr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pbit_q, pbit_d, perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
  rx_entry_t         wr_ent, rd_ent;
  logic              fifo_full, fifo_empty, pop;

  // Front end: synchroniser, sample history and bit vote
  assign rxs = sync_q[1];

  always_comb begin
    sync_d = cfg_en_i ? {sync_q[0], rx_i} : 2'b11;
    hist_d = cfg_en_i ? HIST_W'({hist_q, rxs}) : '1;
`ifdef UART_RX_MAJORITY_EN
    bit_s  = maj3(rxs, hist_q[0], hist_q[1]);
`else
    bit_s  = rxs;
`endif
  end

  // Frame FSM and baud counter
  always_comb begin
    nbits   = clamp_bits(cfg_bits_i);
    sample  = (state_q == ST_START) ? (cnt_q == (cfg_div_i >> 1)) : (cnt_q == cfg_div_i);
    state_d = state_q;
    cnt_d   = sample ? '0 : cnt_q + DIV_W'(1);
    bitc_d  = bitc_q;
    data_d  = data_q;
    pbit_d  = pbit_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    brk_d   = brk_q;
    push_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (hist_q[0] & ~rxs) state_d = ST_START;
      end
      ST_START: if (sample) begin
        if (bit_s) state_d = ST_IDLE;
        else begin
          state_d = ST_DATA;
          bitc_d  = '0;
          data_d  = '0;
          pbit_d  = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          brk_d   = 1'b0;
        end
      end
      ST_DATA: if (sample) begin
        data_d[bitc_q] = bit_s;
        bitc_d         = bitc_q + 4'd1;
        if (bitc_d == nbits) state_d = cfg_parity_en_i ? ST_PARITY : ST_STOP1;
      end
      ST_PARITY: if (sample) begin
        pbit_d  = bit_s;
        perr_d  = (parity_of(MAX_DATA_W'(data_q)) ^ bit_s) != cfg_parity_odd_i;
        state_d = ST_STOP1;
      end
      ST_STOP1: if (sample) begin
        if (!bit_s) ferr_d = 1'b1;
        // Break: an all-zero frame whose first stop bit is also low
        brk_d = ~bit_s & (data_q == '0) & (~cfg_parity_en_i | ~pbit_q);
        if (cfg_stop2_i) state_d = ST_STOP2;
        else begin
          push_d  = 1'b1;
          state_d = ferr_d ? ST_WAIT_IDLE : ST_IDLE;
        end
      end
      ST_STOP2: if (sample) begin
        if (!bit_s) ferr_d = 1'b1;
        push_d  = 1'b1;
        state_d = ferr_d ? ST_WAIT_IDLE : ST_IDLE;
      end
      ST_WAIT_IDLE: begin
        // Stay here while the line is held low so a break is not re-read as starts
        cnt_d = '0;
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!cfg_en_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      push_d  = 1'b0;
    end
  end

  // Push stage: FIFO write and overrun flag
  always_comb begin
    wr_ent.ferr = ferr_q;
    wr_ent.perr = perr_q;
    wr_ent.data = MAX_DATA_W'(data_q);
    pop         = rx_ready_i & rx_valid_o;
    ovr_d       = ovr_q;
    if (err_clr_i) ovr_d = 1'b0;
    if (push_q & fifo_full & ~pop & ~fifo_clr_i) ovr_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      hist_q  <= '1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bitc_q  <= '0;
      push_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitc_q  <= bitc_d;
      push_q  <= push_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
    pbit_q <= pbit_d;
    perr_q <= perr_d;
    ferr_q <= ferr_d;
    brk_q  <= brk_d;
  end

  uart_rx_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_q),
    .wdata_i (wr_ent),
    .pop_i   (pop),
    .clr_i   (fifo_clr_i),
    .rdata_o (rd_ent),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  // Output stage: head is masked to zero while the FIFO is empty
  assign rx_valid_o = ~fifo_empty;
  assign rx_data_o  = rx_valid_o ? DATA_W'(rd_ent.data) : '0;
  assign rx_perr_o  = rx_valid_o & rd_ent.perr;
  assign rx_ferr_o  = rx_valid_o & rd_ent.ferr;
  assign busy_o     = (state_q != ST_IDLE);
  assign break_o    = push_q & brk_q;
  assign err_ovr_o  = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo_gen.sv
module tb_uart_rx_fifo_gen;
  localparam int DATA_W     = 9;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_CYC    = 16;
  localparam int NVEC       = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_i, cfg_en_i, cfg_parity_en_i, cfg_parity_odd_i, cfg_stop2_i;
  logic [DIV_W-1:0]  cfg_div_i;
  logic [3:0]        cfg_bits_i;
  logic              fifo_clr_i, rx_ready_i, err_clr_i;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_perr_o, rx_ferr_o, rx_valid_o, busy_o, break_o, err_ovr_o;
  logic [LVL_W-1:0]  fifo_level_o;

  int total = 0;
  int bad   = 0;
  int brk_cnt = 0;
  int brk_base;
  logic [8:0] glitch_exp;

  always #5 clk = ~clk;

  always @(negedge clk) if (break_o) brk_cnt <= brk_cnt + 1;

  uart_rx_fifo_gen #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .rx_i             (rx_i),
    .cfg_en_i         (cfg_en_i),
    .cfg_div_i        (cfg_div_i),
    .cfg_bits_i       (cfg_bits_i),
    .cfg_parity_en_i  (cfg_parity_en_i),
    .cfg_parity_odd_i (cfg_parity_odd_i),
    .cfg_stop2_i      (cfg_stop2_i),
    .fifo_clr_i       (fifo_clr_i),
    .rx_data_o        (rx_data_o),
    .rx_perr_o        (rx_perr_o),
    .rx_ferr_o        (rx_ferr_o),
    .rx_valid_o       (rx_valid_o),
    .rx_ready_i       (rx_ready_i),
    .fifo_level_o     (fifo_level_o),
    .busy_o           (busy_o),
    .break_o          (break_o),
    .err_ovr_o        (err_ovr_o),
    .err_clr_i        (err_clr_i)
  );

  typedef struct {
    logic [8:0] data;
    logic [3:0] cfg_bits;
    int         nbits;
    bit         par_en;
    bit         par_odd;
    bit         pbit;
    bit         stop2;
    bit         stopv;
    logic [8:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [8:0] d, input int nb, input bit pe, input bit pb,
                            input bit s2, input bit sv, input int glitch);
    logic [19:0] fr;
    int n;
    fr = '0;
    n  = 1;
    for (int i = 0; i < nb; i++) begin
      fr[n] = d[i];
      n++;
    end
    if (pe) begin
      fr[n] = pb;
      n++;
    end
    fr[n] = sv;
    n++;
    if (s2) begin
      fr[n] = 1'b1;
      n++;
    end
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < BIT_CYC; c++) begin
        rx_i = ((b * BIT_CYC + c) == glitch) ? ~fr[b] : fr[b];
        tick(1);
      end
    end
    rx_i = 1'b1;
    tick(8);
  endtask

  task automatic pop_check(input string name, input logic [8:0] d, input bit pe, input bit fe);
    check({name, "_valid"}, 32'(rx_valid_o), 32'd1);
    check({name, "_data"},  32'(rx_data_o),  32'(d));
    check({name, "_perr"},  32'(rx_perr_o),  32'(pe));
    check({name, "_ferr"},  32'(rx_ferr_o),  32'(fe));
    rx_ready_i = 1'b1;
    tick(1);
    rx_ready_i = 1'b0;
  endtask

  task automatic set_cfg(input logic [3:0] b, input bit pe, input bit po, input bit s2);
    cfg_bits_i       = b;
    cfg_parity_en_i  = pe;
    cfg_parity_odd_i = po;
    cfg_stop2_i      = s2;
  endtask

  initial begin
    rst = 1'b1; rx_i = 1'b1; cfg_en_i = 1'b1; cfg_div_i = 16'd15;
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    fifo_clr_i = 1'b0; rx_ready_i = 1'b0; err_clr_i = 1'b0;

    //        data     bits  nb par odd pb s2 sv  exp      perr ferr
    vecs[0] = '{9'h0A5, 4'd8,  8, 0, 0, 0, 0, 1, 9'h0A5, 0, 0};
    vecs[1] = '{9'h035, 4'd7,  7, 1, 1, 0, 0, 1, 9'h035, 1, 0};
    vecs[2] = '{9'h035, 4'd7,  7, 1, 1, 1, 0, 1, 9'h035, 0, 0};
    vecs[3] = '{9'h035, 4'd7,  7, 1, 1, 0, 1, 1, 9'h035, 1, 0};
    vecs[4] = '{9'h035, 4'd7,  7, 1, 1, 1, 1, 1, 9'h035, 0, 0};
    vecs[5] = '{9'h1FF, 4'd9,  9, 1, 0, 1, 0, 1, 9'h1FF, 0, 0};
    vecs[6] = '{9'h00F, 4'd3,  5, 0, 0, 0, 0, 1, 9'h00F, 0, 0};
    vecs[7] = '{9'h155, 4'd12, 9, 0, 0, 0, 0, 1, 9'h155, 0, 0};
    vecs[8] = '{9'h03C, 4'd8,  8, 0, 0, 0, 0, 0, 9'h03C, 0, 1};

    tick(3);
    check("rst_valid", 32'(rx_valid_o),   32'd0);
    check("rst_data",  32'(rx_data_o),    32'd0);
    check("rst_perr",  32'(rx_perr_o),    32'd0);
    check("rst_ferr",  32'(rx_ferr_o),    32'd0);
    check("rst_level", 32'(fifo_level_o), 32'd0);
    check("rst_busy",  32'(busy_o),       32'd0);
    check("rst_break", 32'(break_o),      32'd0);
    check("rst_ovr",   32'(err_ovr_o),    32'd0);
    rst = 1'b0;
    tick(5);

    for (int v = 0; v < NVEC; v++) begin
      set_cfg(vecs[v].cfg_bits, vecs[v].par_en, vecs[v].par_odd, vecs[v].stop2);
      send_frame(vecs[v].data, vecs[v].nbits, vecs[v].par_en, vecs[v].pbit,
                 vecs[v].stop2, vecs[v].stopv, -1);
      check($sformatf("vec%0d_level", v), 32'(fifo_level_o), 32'd1);
      pop_check($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_perr, vecs[v].exp_ferr);
      check($sformatf("vec%0d_empty", v), 32'(rx_valid_o), 32'd0);
      check($sformatf("vec%0d_busy", v), 32'(busy_o), 32'd0);
    end
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);

    // False start: 3-cycle low pulse
    rx_i = 1'b0;
    tick(3);
    rx_i = 1'b1;
    tick(4);
    check("fs_busy_hi", 32'(busy_o), 32'd1);
    tick(20);
    check("fs_busy_lo", 32'(busy_o),       32'd0);
    check("fs_level",   32'(fifo_level_o), 32'd0);

    // Disabling mid-frame discards it
    rx_i = 1'b0;
    tick(30);
    check("en_busy_hi", 32'(busy_o), 32'd1);
    cfg_en_i = 1'b0;
    tick(1);
    check("en_busy_lo", 32'(busy_o), 32'd0);
    rx_i = 1'b1;
    tick(3);
    cfg_en_i = 1'b1;
    tick(20);
    check("en_level", 32'(fifo_level_o), 32'd0);
    check("en_busy",  32'(busy_o),       32'd0);

    // Overrun: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_frame(9'(i * 17), 8, 0, 0, 0, 1, -1);
    check("ovr_level", 32'(fifo_level_o), 32'd4);
    check("ovr_flag",  32'(err_ovr_o),    32'd1);
    for (int i = 1; i <= 4; i++) pop_check($sformatf("ovr_pop%0d", i), 9'(i * 17), 0, 0);
    check("ovr_empty",  32'(rx_valid_o), 32'd0);
    check("ovr_sticky", 32'(err_ovr_o),  32'd1);
    err_clr_i = 1'b1;
    tick(1);
    err_clr_i = 1'b0;
    check("ovr_clr", 32'(err_ovr_o), 32'd0);

    // Pop while empty is ignored
    rx_ready_i = 1'b1;
    tick(2);
    rx_ready_i = 1'b0;
    check("uflow_level", 32'(fifo_level_o), 32'd0);

    // Flush
    send_frame(9'h012, 8, 0, 0, 0, 1, -1);
    send_frame(9'h034, 8, 0, 0, 0, 1, -1);
    check("clr_level_pre", 32'(fifo_level_o), 32'd2);
    fifo_clr_i = 1'b1;
    tick(1);
    fifo_clr_i = 1'b0;
    check("clr_level", 32'(fifo_level_o), 32'd0);
    check("clr_valid", 32'(rx_valid_o),   32'd0);

    // Break: line low for 20 bit times
    brk_base = brk_cnt;
    rx_i = 1'b0;
    tick(20 * BIT_CYC);
    check("brk_pulses", 32'(brk_cnt - brk_base), 32'd1);
    check("brk_level",  32'(fifo_level_o),       32'd1);
    check("brk_busy",   32'(busy_o),             32'd1);
    rx_i = 1'b1;
    tick(20);
    check("brk_idle",   32'(busy_o),       32'd0);
    check("brk_level2", 32'(fifo_level_o), 32'd1);
    send_frame(9'h055, 8, 0, 0, 0, 1, -1);
    check("brk_level3", 32'(fifo_level_o), 32'd2);
    pop_check("brk_entry", 9'h000, 0, 1);
    pop_check("brk_after", 9'h055, 0, 0);

    // One-cycle high glitch at the mid-bit sample of data bit 2
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 9'h000;
`else
    glitch_exp = 9'h004;
`endif
    send_frame(9'h000, 8, 0, 0, 0, 1, 3 * BIT_CYC + 8);
    pop_check("glitch", glitch_exp, 0, 0);
    check("final_ovr", 32'(err_ovr_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
